amp_out_period_meter: RTL and testbench



---
 rtl/amp_meas_pkg.sv | 25 ++
 rtl/amp_meas_fifo.sv | 74 +++++++
 rtl/amp_out_period_meter.sv | 161 ++++++++++++++++
 tb/tb_amp_out_period_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/amp_meas_pkg.sv
// rtl/amp_meas_pkg.sv - shared types and helpers for the OUT period meter
// Contents:
//   state_t    : measurement FSM states
//   meas_t     : default measurement record {ovf, period}
//   ptr_width  : FIFO pointer width for a power-of-two depth
package amp_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int MEAS_CNT_W = 16;

  typedef struct packed {
    logic                  ovf;
    logic [MEAS_CNT_W-1:0] period;
  } meas_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/amp_meas_fifo.sv
// rtl/amp_meas_fifo.sv - synchronous measurement FIFO with a registered head
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write request (accepted when not full, or when full with a pop)
//   i_data     : record to write
//   i_pop      : remove head entry (ignored when empty)
//   o_full     : FIFO_DEPTH entries held
//   o_empty    : no entries held
//   o_head     : registered copy of the oldest entry
module amp_meas_fifo
  import amp_meas_pkg::*;
#(
  parameter type T          = meas_t,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int PW = ptr_width(FIFO_DEPTH);

  T              r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  T              r_head;

  logic          w_pop;
  logic          w_push_acc;
  logic [PW-1:0] w_rd_nxt;
  T              w_head_nxt;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop      = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push_acc = i_push && (!o_full || w_pop);
  assign w_rd_nxt   = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
  // The only way the next head slot equals the write slot with a write pending
  // is an empty (or emptying) FIFO: bypass the incoming record to the head.
  assign w_head_nxt = (w_push_acc && (w_rd_nxt == r_wr_ptr)) ? i_data : r_mem[w_rd_nxt];
  assign o_head     = r_head;

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_nxt;
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_acc || w_pop) r_head <= w_head_nxt;
    end
  end

endmodule

// File: rtl/amp_out_period_meter.sv
// rtl/amp_out_period_meter.sv - synchronise, debounce and time the amplifier OUT signal
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   out_i        : comparator-digitised amplifier output (asynchronous)
//   enable       : measurement enable
//   level_o      : debounced, polarity-corrected level
//   meas_valid   : measurement FIFO non-empty
//   meas_ready   : consumer takes the head entry
//   meas_period  : head entry, clk cycles between rising edges of level_o
//   meas_ovf     : head entry saturated
//   overrun      : sticky, a measurement was dropped on a full FIFO
//   clr_overrun  : clears overrun (a simultaneous drop wins)
module amp_out_period_meter
  import amp_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter bit INVERT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             out_i,
  input  logic             enable,
  output logic             level_o,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_ovf,
  output logic             overrun,
  input  logic             clr_overrun
);

  typedef struct packed {
    logic             ovf;
    logic [CNT_W-1:0] period;
  } meas_rec_t;

  localparam int               DW      = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_deb_cnt;
  logic                   r_level;
  logic                   r_level_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;
  logic                   r_overrun;

  logic      w_sync_c;
  logic      w_rise;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  meas_rec_t w_push_data;
  meas_rec_t w_head;

  // The filter works on the polarity-corrected value, so its state is level_o
  // itself and the reset value of 0 is also the reset value of the output.
  assign w_sync_c = r_sync[SYNC_STAGES-1] ^ INVERT;
  assign w_rise   = r_level && !r_level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_deb_cnt <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], out_i};
      r_level_d <= r_level;
      if (w_sync_c == r_level) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DW'(DEBOUNCE - 1)) begin
        // This differing cycle is the DEBOUNCE-th in a row.
        r_level   <= ~r_level;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= ARM;
        end
        ARM: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_sat   <= 1'b0;
            r_state <= MEASURE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            r_cnt <= CNT_W'(1);
            r_sat <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_sat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_sat   <= 1'b0;
        end
      endcase
    end
  end

  assign w_push      = enable && (r_state == MEASURE) && w_rise;
  assign w_push_data = '{ovf: r_sat, period: r_cnt};
  assign w_pop       = !w_empty && meas_ready;

  amp_meas_fifo #(
    .T          (meas_rec_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign level_o     = r_level;
  assign meas_valid  = !w_empty;
  assign meas_period = w_head.period;
  assign meas_ovf    = w_head.ovf;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_amp_out_period_meter.sv
// tb/tb_amp_out_period_meter.sv - self-checking bench for amp_out_period_meter
module tb_amp_out_period_meter;
  import amp_meas_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_i;
  logic        enable;
  logic        meas_ready;
  logic        clr_overrun;
  logic        level_o, meas_valid, meas_ovf, overrun;
  logic [15:0] meas_period;

  logic        s_ready = 1'b1;
  logic        s_clr   = 1'b0;
  logic        s_level, s_valid, s_ovf, s_overrun;
  logic [3:0]  s_period;

  int n_tests = 0;
  int n_fail  = 0;
  int mq[$], sq[$], exp_m[$], exp_s[$], ds[$];

  always #5 clk = ~clk;

  amp_out_period_meter u_dut (
    .clk(clk), .rst_n(rst_n), .out_i(out_i), .enable(enable),
    .level_o(level_o), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_period(meas_period), .meas_ovf(meas_ovf), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  amp_out_period_meter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .out_i(out_i), .enable(enable),
    .level_o(s_level), .meas_valid(s_valid), .meas_ready(s_ready),
    .meas_period(s_period), .meas_ovf(s_ovf), .overrun(s_overrun),
    .clr_overrun(s_clr)
  );

  // Record every entry the consumer actually takes, encoded ovf<<20 | period.
  always @(negedge clk) begin
    if (rst_n && meas_valid && meas_ready)
      mq.push_back(int'(meas_ovf) * (1 << 20) + int'(meas_period));
    if (rst_n && s_valid && s_ready)
      sq.push_back(int'(s_ovf) * (1 << 20) + int'(s_period));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
  endtask

  // Reference: with INVERT=1 every falling step of out_i is one rise of level_o,
  // so a period equals the spacing of out_i falls, clipped to the counter range.
  function automatic int enc(input int d, input int w);
    int lim = (1 << w) - 1;
    return (d > lim) ? ((1 << 20) | lim) : d;
  endfunction

  // One out_i fall followed by d cycles until the next call's fall.
  task automatic gen_period(input int d);
    out_i = 1'b0;
    tick(d / 2);
    out_i = 1'b1;
    tick(d - d / 2);
  endtask

  task automatic run_train(input int q[$]);
    foreach (q[i]) gen_period(q[i]);
  endtask

  initial begin
    // ---- reset values and debounce ----
    rst_n = 1'b0; out_i = 1'b1; enable = 1'b0; meas_ready = 1'b1; clr_overrun = 1'b0;
    tick(3);
    check("rst_level", level_o, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_period", meas_period, 0);
    check("rst_ovf", meas_ovf, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat_valid", s_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("post_rst_level_%0d", i), level_o, 0);
    end
    out_i = 1'b0; tick(3); out_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("glitch_level_%0d", i), level_o, 0);
    end
    out_i = 1'b0;
    tick(5);
    check("latency_5", level_o, 0);
    tick(1);
    check("latency_6", level_o, 1);
    out_i = 1'b1;
    tick(8);
    check("latency_back", level_o, 0);

    // ---- basic periods, random intervals ----
    mq.delete(); exp_m.delete();
    enable = 1'b1; tick(2);
    ds = '{20, 20, 20, 20, 20};
    for (int i = 0; i < 4; i++) ds.push_back(int'($urandom_range(10, 40)));
    ds.push_back(10);
    run_train(ds);
    tick(15);
    for (int i = 0; i < ds.size() - 1; i++) exp_m.push_back(enc(ds[i], 16));
    check_q("basic", mq, exp_m);
    enable = 1'b0; tick(2);

    // ---- saturation (4-bit instance) ----
    mq.delete(); sq.delete(); exp_m.delete(); exp_s.delete();
    enable = 1'b1; tick(2);
    ds = '{25, 10};
    for (int i = 0; i < 4; i++) ds.push_back(int'($urandom_range(10, 30)));
    ds.push_back(15); ds.push_back(16); ds.push_back(10);
    run_train(ds);
    tick(15);
    for (int i = 0; i < ds.size() - 1; i++) begin
      exp_m.push_back(enc(ds[i], 16));
      exp_s.push_back(enc(ds[i], 4));
    end
    check_q("sat4", sq, exp_s);
    check_q("sat16", mq, exp_m);
    enable = 1'b0; tick(2);

    // ---- FIFO full and overrun ----
    mq.delete(); exp_m.delete();
    meas_ready = 1'b0;
    enable = 1'b1; tick(2);
    ds = '{12, 12, 12, 12, 19, 21, 10};
    run_train(ds);
    tick(10);
    check("ovr_set", overrun, 1);
    check("ovr_valid", meas_valid, 1);
    check("ovr_head", meas_period, 12);
    check("ovr_nopop", mq.size(), 0);
    meas_ready = 1'b1;
    tick(6);
    exp_m = '{12, 12, 12, 12};
    check_q("ovr_drain", mq, exp_m);
    check("ovr_empty", meas_valid, 0);
    check("ovr_sticky", overrun, 1);
    clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
    check("ovr_clr", overrun, 0);
    enable = 1'b0; tick(2);

    // ---- push and pop together on a full FIFO ----
    mq.delete();
    meas_ready = 1'b0;
    enable = 1'b1; tick(2);
    ds = '{12, 12, 12, 12, 17};
    run_train(ds);
    out_i = 1'b0;
    tick(6);
    meas_ready = 1'b1;
    tick(1);
    meas_ready = 1'b0;
    tick(3);
    out_i = 1'b1;
    tick(8);
    check("pp_no_overrun", overrun, 0);
    check("pp_valid", meas_valid, 1);
    meas_ready = 1'b1;
    tick(8);
    exp_m = '{12, 12, 12, 12, 17};
    check_q("pp_drain", mq, exp_m);
    enable = 1'b0; tick(2);

    // ---- enable drop mid-interval ----
    mq.delete(); exp_m.delete();
    enable = 1'b1; tick(2);
    gen_period(15);
    gen_period(15);
    out_i = 1'b0;
    tick(10);
    enable = 1'b0;
    tick(1);
    check("drop_idle", 32'(u_dut.r_state), 32'(IDLE));
    out_i = 1'b1;
    tick(30);
    exp_m = '{15, 15};
    check_q("drop_hold", mq, exp_m);
    enable = 1'b1; tick(2);
    ds = '{0, 0, 10};
    ds[0] = int'($urandom_range(10, 30));
    ds[1] = int'($urandom_range(10, 30));
    run_train(ds);
    tick(15);
    exp_m.push_back(ds[0]);
    exp_m.push_back(ds[1]);
    check_q("reenable", mq, exp_m);
    enable = 1'b0; tick(2);

    // ---- asynchronous reset with entries queued ----
    mq.delete();
    meas_ready = 1'b0;
    enable = 1'b1; tick(2);
    ds = '{12, 12, 12, 12};
    run_train(ds);
    tick(10);
    check("ar_valid_before", meas_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", meas_valid, 0);
    check("ar_overrun", overrun, 0);
    check("ar_period", meas_period, 0);
    check("ar_level", level_o, 0);
    tick(3);
    rst_n = 1'b1;
    meas_ready = 1'b1;
    tick(20);
    check("ar_no_stale", mq.size(), 0);
    check("ar_valid_after", meas_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
